// File: rtl/axi_dma_pkg.sv
// rtl/axi_dma_pkg.sv - shared AXI constants, FSM state type and helpers for the read DMA
package axi_dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY      = 2'b00;
    localparam int         AXI_BOUNDARY_BYTES = 4096;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } dma_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// rtl/axi_burst_calc.sv - burst length for the next AR: min of remaining, max burst and beats to 4 KB
module axi_burst_calc
    import axi_dma_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int LEN_WIDTH     = 20,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [11:0]          addr_offset,
    input  logic [LEN_WIDTH-1:0] remaining,
    output logic [8:0]           beats,
    output logic [7:0]           arlen
);

    localparam int BYTE_SHIFT = clog2(DATA_WIDTH / 8);
    localparam int CW         = (LEN_WIDTH > 14) ? LEN_WIDTH : 14;

    logic [12:0]   bytes_to_boundary;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] bnd_w;
    logic [CW-1:0] cap_w;
    logic [CW-1:0] min_a;
    logic [CW-1:0] min_b;
    logic          unused_hi;

    // Offset within the 4 KB page is always aligned, so the shift is exact.
    assign bytes_to_boundary = 13'(AXI_BOUNDARY_BYTES) - {1'b0, addr_offset};
    assign rem_w             = CW'(remaining);
    assign bnd_w             = CW'(bytes_to_boundary >> BYTE_SHIFT);
    assign cap_w             = CW'(MAX_BURST_LEN);

    assign min_a = (rem_w < cap_w) ? rem_w : cap_w;
    assign min_b = (min_a < bnd_w) ? min_a : bnd_w;

    // min_b is 1..256 whenever it is used; 256 wraps to arlen 255 as intended.
    assign beats     = min_b[8:0];
    assign arlen     = min_b[7:0] - 8'd1;
    assign unused_hi = ^min_b[CW-1:9];

endmodule

// File: rtl/axi_read_dma.sv
// rtl/axi_read_dma.sv - AXI4 read-burst master splitting commands into 4 KB-safe INCR bursts
module axi_read_dma
    import axi_dma_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int DMA_ID          = 0,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_WIDTH       = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done,
    output logic                  done_err,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = clog2(BYTES);
    localparam int OUT_W      = clog2(MAX_OUTSTANDING + 1);

    dma_state_t state;
    dma_state_t state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [LEN_WIDTH-1:0]  beats_left_q;
    logic [OUT_W-1:0]      outstanding_q;
    logic                  err_q;
    logic                  arvalid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic [8:0]            burst_beats_q;

    logic [8:0]            calc_beats;
    logic [7:0]            calc_arlen;
    logic                  cmd_hs;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  rlast_hs;
    logic                  ar_launch;
    logic                  unused_resp;

    axi_burst_calc #(
        .DATA_WIDTH    (DATA_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .addr_offset (addr_q[11:0]),
        .remaining   (remaining_q),
        .beats       (calc_beats),
        .arlen       (calc_arlen)
    );

    assign cmd_ready = (state == IDLE) && !rst;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign ar_hs     = arvalid_q && m_axi_arready;
    assign r_hs      = m_axi_rvalid && out_ready;
    assign rlast_hs  = r_hs && m_axi_rlast;

    // A new AR is only raised from idle AR state, so the held beat count stays with its address.
    assign ar_launch = (state == ISSUE) && !arvalid_q && (remaining_q != '0)
                     && (outstanding_q < OUT_W'(MAX_OUTSTANDING));

    assign m_axi_arid    = ID_WIDTH'(DMA_ID);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(BYTE_SHIFT);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = arvalid_q;

    assign out_data     = m_axi_rdata;
    assign out_valid    = m_axi_rvalid;
    assign out_last     = m_axi_rvalid && (beats_left_q == LEN_WIDTH'(1));
    assign m_axi_rready = out_ready;
    assign unused_resp  = m_axi_rresp[0];

    assign done     = (state == DONE);
    assign done_err = (state == DONE) && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    state_next = (cmd_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if ((remaining_q == '0) && !arvalid_q) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (beats_left_q == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q        <= '0;
            remaining_q   <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            burst_beats_q <= '0;
        end else begin
            if (cmd_hs) begin
                addr_q      <= cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
                remaining_q <= cmd_len;
            end
            if (ar_launch) begin
                arvalid_q     <= 1'b1;
                araddr_q      <= addr_q;
                arlen_q       <= calc_arlen;
                burst_beats_q <= calc_beats;
            end else if (ar_hs) begin
                arvalid_q   <= 1'b0;
                addr_q      <= addr_q + (ADDR_WIDTH'(burst_beats_q) << BYTE_SHIFT);
                remaining_q <= remaining_q - LEN_WIDTH'(burst_beats_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_left_q  <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (cmd_hs) begin
                beats_left_q <= cmd_len;
            end else if (r_hs && (beats_left_q != '0)) begin
                beats_left_q <= beats_left_q - LEN_WIDTH'(1);
            end

            if (cmd_hs) begin
                err_q <= 1'b0;
            end else if (r_hs && m_axi_rresp[1]) begin
                err_q <= 1'b1;
            end

            // Simultaneous AR accept and burst completion leave the count unchanged.
            case ({ar_hs, rlast_hs})
                2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
                2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - OUT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_dma.sv
// tb/tb_axi_read_dma.sv - directed self-checking bench for axi_read_dma
module tb_axi_read_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_addr;
    logic [19:0] cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        done_err;
    logic [7:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        ar_ready_en;
    logic [31:0] m_axi_rdata  = '0;
    logic [1:0]  m_axi_rresp  = '0;
    logic        m_axi_rlast  = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    logic        r_en     = 1'b1;
    int          err_beat = 0;
    int          errors   = 0;
    int          checks   = 0;

    always #5 clk = ~clk;

    axi_read_dma dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .done          (done),
        .done_err      (done_err),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (ar_ready_en),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    // Per-command logs filled by the monitor, cleared on each command handshake.
    int          cyc = 0;
    int          ar_cnt = 0;
    logic [31:0] ar_addr_l [16];
    logic [7:0]  ar_len_l  [16];
    int          ar_cyc_l  [16];
    int          beat_cnt = 0;
    int          last_cnt = 0;
    int          last_beat = 0;
    int          data_bad = 0;
    int          first_rlast_cyc = 0;
    bit          got_rlast = 0;
    bit          arv_seen = 0;

    bit          ar_hs_s, r_hs_s, cmd_hs_s;
    logic [7:0]  ar_len_s;
    logic [7:0]  len_q [$];
    int          slave_beat = 0;
    int          burst_beat = 0;

    // Monitor samples mid-cycle; the slave model updates just after each rising edge.
    always begin
        @(negedge clk);
        cyc++;
        ar_hs_s  = !rst && m_axi_arvalid && ar_ready_en;
        r_hs_s   = !rst && m_axi_rvalid && m_axi_rready;
        cmd_hs_s = !rst && cmd_valid && cmd_ready;
        ar_len_s = m_axi_arlen;
        if (cmd_hs_s) begin
            ar_cnt = 0; beat_cnt = 0; last_cnt = 0; last_beat = 0;
            data_bad = 0; got_rlast = 0; first_rlast_cyc = 0; arv_seen = 0;
        end
        if (m_axi_arvalid) arv_seen = 1;
        if (ar_hs_s) begin
            if (ar_cnt < 16) begin
                ar_addr_l[ar_cnt] = m_axi_araddr;
                ar_len_l[ar_cnt]  = m_axi_arlen;
                ar_cyc_l[ar_cnt]  = cyc;
            end
            ar_cnt++;
        end
        if (r_hs_s) begin
            beat_cnt++;
            if (out_data !== 32'hA500_0000 + 32'(beat_cnt)) data_bad++;
            if (out_last) begin
                last_cnt++;
                last_beat = beat_cnt;
            end
            if (m_axi_rlast && !got_rlast) begin
                got_rlast       = 1;
                first_rlast_cyc = cyc;
            end
        end

        @(posedge clk);
        #1;
        if (rst) begin
            len_q.delete();
            slave_beat = 0;
            burst_beat = 0;
        end else begin
            if (cmd_hs_s) slave_beat = 0;
            if (r_hs_s && len_q.size() > 0) begin
                slave_beat++;
                if (burst_beat == int'(len_q[0])) begin
                    void'(len_q.pop_front());
                    burst_beat = 0;
                end else begin
                    burst_beat++;
                end
            end
            if (ar_hs_s) len_q.push_back(ar_len_s);
        end
        m_axi_rvalid = r_en && (len_q.size() > 0) && !rst;
        m_axi_rdata  = 32'hA500_0000 + 32'(slave_beat + 1);
        m_axi_rlast  = (len_q.size() > 0) ? (burst_beat == int'(len_q[0])) : 1'b0;
        m_axi_rresp  = (slave_beat + 1 == err_beat) ? 2'b10 : 2'b00;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [19:0] l);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        chk("cmd_accept", ok, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output logic derr);
        bit seen;
        seen = 0;
        derr = 1'bx;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                derr = done_err;
                break;
            end
        end
        chk("done_seen", seen, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic wait_arvalid();
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_axi_arvalid) begin
                seen = 1;
                break;
            end
        end
        chk("arvalid_rise", seen, 1);
    endtask

    logic derr;

    initial begin
        rst         = 1'b1;
        cmd_addr    = '0;
        cmd_len     = '0;
        cmd_valid   = 1'b0;
        out_ready   = 1'b1;
        ar_ready_en = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_arburst", m_axi_arburst, 2'b01);
        chk("rst_arsize", m_axi_arsize, 3'd2);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        // 40 beats from 0x1000: 16 + 16 + 8
        start_cmd(32'h1000, 20'd40);
        wait_done(300, derr);
        chk("t1_ar_cnt", ar_cnt, 3);
        chk("t1_ar0_addr", ar_addr_l[0], 32'h1000);
        chk("t1_ar0_len", ar_len_l[0], 15);
        chk("t1_ar1_addr", ar_addr_l[1], 32'h1040);
        chk("t1_ar1_len", ar_len_l[1], 15);
        chk("t1_ar2_addr", ar_addr_l[2], 32'h1080);
        chk("t1_ar2_len", ar_len_l[2], 7);
        chk("t1_beats", beat_cnt, 40);
        chk("t1_last_cnt", last_cnt, 1);
        chk("t1_last_beat", last_beat, 40);
        chk("t1_data", data_bad, 0);
        chk("t1_done_err", derr, 0);

        // 4 KB crossing split: 4 beats before the boundary, 4 after
        start_cmd(32'h0FF0, 20'd8);
        wait_done(200, derr);
        chk("t2_ar_cnt", ar_cnt, 2);
        chk("t2_ar0_addr", ar_addr_l[0], 32'h0FF0);
        chk("t2_ar0_len", ar_len_l[0], 3);
        chk("t2_ar1_addr", ar_addr_l[1], 32'h1000);
        chk("t2_ar1_len", ar_len_l[1], 3);
        chk("t2_beats", beat_cnt, 8);

        // Zero-length command
        start_cmd(32'h5000, 20'd0);
        @(negedge clk);
        chk("t3_done", done, 1);
        chk("t3_done_err", done_err, 0);
        chk("t3_cmd_ready_busy", cmd_ready, 0);
        @(negedge clk);
        chk("t3_cmd_ready_back", cmd_ready, 1);
        chk("t3_done_low", done, 0);
        chk("t3_no_arvalid", arv_seen, 0);

        // AR stall: request held stable for 5 cycles, then one handshake
        ar_ready_en = 1'b0;
        start_cmd(32'h0000, 20'd16);
        wait_arvalid();
        for (int i = 0; i < 5; i++) begin
            chk("t4_arvalid_hold", m_axi_arvalid, 1);
            chk("t4_araddr_hold", m_axi_araddr, 32'h0);
            chk("t4_arlen_hold", m_axi_arlen, 15);
            @(negedge clk);
        end
        @(posedge clk);
        #1 ar_ready_en = 1'b1;
        wait_done(200, derr);
        chk("t4_ar_cnt", ar_cnt, 1);
        chk("t4_beats", beat_cnt, 16);

        // Outstanding limit: R withheld, only 4 ARs may issue
        r_en = 1'b0;
        start_cmd(32'h0000, 20'd128);
        repeat (20) @(negedge clk);
        chk("t5_ar_cnt_cap", ar_cnt, 4);
        chk("t5_arvalid_low", m_axi_arvalid, 0);
        @(posedge clk);
        #1 r_en = 1'b1;
        wait_done(600, derr);
        chk("t5_ar_cnt", ar_cnt, 8);
        chk("t5_ar5_after_rlast", (ar_cyc_l[4] > first_rlast_cyc), 1);
        chk("t5_beats", beat_cnt, 128);
        chk("t5_last_beat", last_beat, 128);
        chk("t5_data", data_bad, 0);

        // Error response on beat 3: all beats still delivered, error flagged
        err_beat = 3;
        start_cmd(32'h2000, 20'd16);
        wait_done(200, derr);
        err_beat = 0;
        chk("t6_beats", beat_cnt, 16);
        chk("t6_last_cnt", last_cnt, 1);
        chk("t6_done_err", derr, 1);

        // Asynchronous reset while an AR is pending
        ar_ready_en = 1'b0;
        start_cmd(32'h4000, 20'd64);
        wait_arvalid();
        #2 rst = 1'b1;
        #1;
        chk("t7_arvalid_async", m_axi_arvalid, 0);
        chk("t7_cmd_ready_rst", cmd_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        ar_ready_en = 1'b1;
        @(negedge clk);
        chk("t7_cmd_ready_after", cmd_ready, 1);
        start_cmd(32'h3000, 20'd4);
        wait_done(200, derr);
        chk("t7_ar_cnt", ar_cnt, 1);
        chk("t7_ar_addr", ar_addr_l[0], 32'h3000);
        chk("t7_ar_len", ar_len_l[0], 3);
        chk("t7_beats", beat_cnt, 4);
        chk("t7_done_err", derr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
